instruction_sequencer: RTL and testbench

Programmable sequencer that sits directly upstream of the master controller and drives its `instruction` input with one instruction word per clock. It holds a small program memory loaded by the host and steps a program counter through it. It executes nested hardware loops and HALT locally, and emits NOP words whenever the controller must idle. Sequencer-only opcodes are consumed here and never reach the controller.

---
 rtl/instruction_sequencer_if.sv | 27 ++
 rtl/instruction_sequencer.sv | 132 +++++++++++++
 tb/tb_instruction_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_if.sv
// Host/controller-facing bundle of the instruction sequencer: program load, run control,
// emitted instruction word and status.
interface instruction_sequencer_if #(
  parameter int unsigned PA       = 8,
  parameter int unsigned insWidth = 26
);
  logic                progWrite;
  logic [PA-1:0]       progAddr;
  logic [insWidth-1:0] progData;
  logic                start;
  logic                hold;
  logic [insWidth-1:0] instruction;
  logic                busy;
  logic                done;
  logic                error;
  logic [PA-1:0]       pc;

  modport master (
    output progWrite, progAddr, progData, start, hold,
    input  instruction, busy, done, error, pc
  );

  modport slave (
    input  progWrite, progAddr, progData, start, hold,
    output instruction, busy, done, error, pc
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Program-memory sequencer feeding the master controller one instruction per clock,
// with local HALT, NOP and nested hardware loops.
module instruction_sequencer #(
  parameter int unsigned depth = 2,
  parameter int unsigned W     = 16,
  parameter int unsigned PA    = 8,
  parameter int unsigned LS    = 2
) (
  input logic                   CLK,
  input logic                   RST,
  instruction_sequencer_if.slave bus
);
  localparam int unsigned D        = 1 << depth;
  localparam int unsigned insW     = (depth > 2) ? depth : 2;
  localparam int unsigned insD     = (D > W) ? D : W;
  localparam int unsigned insWidth = 4 + 2 + 2 * insW + insD;
  localparam int unsigned SPW      = $clog2(LS + 1);
  localparam int unsigned MEM_N    = 1 << PA;
  localparam int unsigned STK_N    = 1 << SPW;

  localparam logic [3:0] OP_NOP        = 4'b0100;
  localparam logic [3:0] OP_HALT       = 4'b0111;
  localparam logic [3:0] OP_LOOP_END   = 4'b1101;
  localparam logic [3:0] OP_LOOP_BEGIN = 4'b1111;

  localparam logic [insWidth-1:0] NOP_WORD = {OP_NOP, {(insWidth - 4){1'b0}}};
  localparam logic [PA-1:0]       PC_LAST  = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [insWidth-1:0] mem [MEM_N];
  logic [PA-1:0]       pc;
  logic [SPW-1:0]      sp;
  logic [PA-1:0]       stk_start [STK_N];
  logic [PA-1:0]       stk_rem   [STK_N];
  logic [insWidth-1:0] instr;
  logic                busy;
  logic                done;
  logic                err;

  logic [insWidth-1:0] word;
  logic [3:0]          opcode;
  logic [PA-1:0]       count;
  logic [SPW-1:0]      top;
  logic                is_local;
  logic                fault;

  assign word     = mem[pc];
  assign opcode   = word[insWidth-1 -: 4];
  assign count    = word[PA-1:0];
  assign top      = sp - SPW'(1);
  assign is_local = (opcode == OP_NOP) || (opcode == OP_HALT) ||
                    (opcode == OP_LOOP_END) || (opcode == OP_LOOP_BEGIN);
  // Any non-HALT word at the last address would wrap pc, so it terminates with an error.
  assign fault    = (opcode != OP_HALT) &&
                    ((pc == PC_LAST) ||
                     ((opcode == OP_LOOP_BEGIN) && (sp == SPW'(LS))) ||
                     ((opcode == OP_LOOP_END) && (sp == '0)));

  assign bus.instruction = instr;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.error       = err;
  assign bus.pc          = pc;

  // Program memory: host writes only while idle, no reset.
  always_ff @(posedge CLK) begin
    if ((state == IDLE) && bus.progWrite) begin
      mem[bus.progAddr] <= bus.progData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pc    <= '0;
      sp    <= '0;
      instr <= NOP_WORD;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done  <= 1'b0;
      instr <= NOP_WORD;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            pc    <= '0;
            sp    <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.hold) begin
            if (opcode == OP_HALT) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (fault) begin
              if (!is_local) instr <= word;
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (opcode == OP_LOOP_BEGIN) begin
              // Stored count is extra passes still owed; N=0 behaves as a single pass.
              stk_start[sp] <= pc + PA'(1);
              stk_rem[sp]   <= (count == '0) ? '0 : count - PA'(1);
              sp            <= sp + SPW'(1);
              pc            <= pc + PA'(1);
            end else if (opcode == OP_LOOP_END) begin
              if (stk_rem[top] != '0) begin
                stk_rem[top] <= stk_rem[top] - PA'(1);
                pc           <= stk_start[top];
              end else begin
                sp <= top;
                pc <= pc + PA'(1);
              end
            end else begin
              if (opcode != OP_NOP) instr <= word;
              pc <= pc + PA'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized and directed bench for instruction_sequencer against a program-level interpreter.
module tb_instruction_sequencer;
  localparam int unsigned PA    = 8;
  localparam int unsigned LS    = 2;
  localparam int unsigned IW    = 26;
  localparam int unsigned MEM_N = 256;

  localparam logic [3:0] OP_NOP   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0111;
  localparam logic [3:0] OP_END   = 4'b1101;
  localparam logic [3:0] OP_BEGIN = 4'b1111;
  localparam logic [3:0] OP_CONV  = 4'b0001;
  localparam logic [3:0] OP_LOADK = 4'b0010;
  localparam logic [3:0] OP_POOL  = 4'b0011;

  localparam logic [IW-1:0] NOP_W = {OP_NOP, 22'd0};

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  instruction_sequencer_if #(.PA(PA), .insWidth(IW)) sif ();

  instruction_sequencer #(.depth(2), .W(16), .PA(PA), .LS(LS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (sif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [IW-1:0] ref_mem [MEM_N];
  logic [IW-1:0] exp_q [$];
  logic [PA-1:0] exp_pc [$];
  bit            exp_err;
  logic [IW-1:0] prog [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [1:0] i1, input logic [15:0] last);
    return {op, i1, 4'b0000, last};
  endfunction

  function automatic bit is_local(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_HALT) || (op == OP_END) || (op == OP_BEGIN);
  endfunction

  function automatic logic [IW-1:0] rnd_fwd();
    logic [3:0] op;
    do op = 4'($urandom_range(15)); while (is_local(op));
    return {op, 22'($urandom)};
  endfunction

  // Interprets ref_mem from address 0: one emitted word per executed program word.
  task automatic build_ref();
    int pcm = 0;
    int st_start [$];
    int st_left [$];
    int ix;
    logic [IW-1:0] w;
    logic [3:0] op;
    bit fin = 1'b0;
    exp_q.delete();
    exp_pc.delete();
    exp_err = 1'b0;
    for (int s = 0; s < 20000 && !fin; s++) begin
      w  = ref_mem[pcm];
      op = w[IW-1 -: 4];
      if (op == OP_HALT) begin
        exp_q.push_back(NOP_W);
        fin = 1'b1;
      end else if (pcm == MEM_N - 1 || (op == OP_BEGIN && st_start.size() == LS) ||
                   (op == OP_END && st_start.size() == 0)) begin
        exp_q.push_back(is_local(op) ? NOP_W : w);
        exp_err = 1'b1;
        fin = 1'b1;
      end else if (op == OP_BEGIN) begin
        st_start.push_back(pcm + 1);
        st_left.push_back((w[PA-1:0] == 0) ? 1 : int'(w[PA-1:0]));
        exp_q.push_back(NOP_W);
        pcm++;
      end else if (op == OP_END) begin
        exp_q.push_back(NOP_W);
        ix = st_left.size() - 1;
        st_left[ix] = st_left[ix] - 1;
        if (st_left[ix] != 0) begin
          pcm = st_start[ix];
        end else begin
          void'(st_start.pop_back());
          void'(st_left.pop_back());
          pcm++;
        end
      end else begin
        exp_q.push_back((op == OP_NOP) ? NOP_W : w);
        pcm++;
      end
      exp_pc.push_back(PA'(pcm));
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) begin
      sif.progWrite = 1'b1;
      sif.progAddr  = PA'(i);
      sif.progData  = prog[i];
      ref_mem[i]    = prog[i];
      @(posedge CLK); #1;
    end
    sif.progWrite = 1'b0;
  endtask

  task automatic run_prog(input string name, input int hold_pct, input int hold_at, input int hold_len,
                          input logic [3:0] tgt, output int tgt_cnt, output int fwd_cnt, output int cycles);
    int k = 0;
    int idx = 0;
    bit h;
    logic [PA-1:0] pc_before;
    logic [3:0] oop;
    build_ref();
    tgt_cnt = 0;
    fwd_cnt = 0;
    sif.start = 1'b1;
    @(posedge CLK); #1;
    sif.start = 1'b0;
    chk({name, ":start_busy"}, 32'(sif.busy), 32'd1);
    chk({name, ":start_pc"}, 32'(sif.pc), 32'd0);
    chk({name, ":start_instr"}, 32'(sif.instruction), 32'(NOP_W));
    chk({name, ":start_err"}, 32'(sif.error), 32'd0);
    while (idx < exp_q.size()) begin
      if (k > 5000) begin
        chk({name, ":timeout"}, 32'(idx), 32'(exp_q.size()));
        break;
      end
      h = ((k >= hold_at) && (k < hold_at + hold_len)) || ($urandom_range(99) < hold_pct);
      sif.hold  = h;
      sif.start = ($urandom_range(7) == 0);
      pc_before = sif.pc;
      @(posedge CLK); #1;
      sif.hold  = 1'b0;
      sif.start = 1'b0;
      k++;
      if (h) begin
        chk({name, ":hold_instr"}, 32'(sif.instruction), 32'(NOP_W));
        chk({name, ":hold_pc"}, 32'(sif.pc), 32'(pc_before));
        chk({name, ":hold_done"}, 32'(sif.done), 32'd0);
      end else begin
        chk({name, ":instr"}, 32'(sif.instruction), 32'(exp_q[idx]));
        oop = sif.instruction[IW-1 -: 4];
        if (oop == tgt) tgt_cnt++;
        if (oop != OP_NOP) fwd_cnt++;
        if (idx == exp_q.size() - 1) begin
          chk({name, ":end_done"}, 32'(sif.done), 32'd1);
          chk({name, ":end_busy"}, 32'(sif.busy), 32'd0);
          chk({name, ":end_err"}, 32'(sif.error), 32'(exp_err));
        end else begin
          chk({name, ":done"}, 32'(sif.done), 32'd0);
          chk({name, ":pc"}, 32'(sif.pc), 32'(exp_pc[idx]));
        end
        idx++;
      end
    end
    cycles = k;
    @(posedge CLK); #1;
    chk({name, ":done_drop"}, 32'(sif.done), 32'd0);
  endtask

  task automatic gen_random();
    int n;
    prog.delete();
    n = $urandom_range(2);
    for (int i = 0; i < n; i++) prog.push_back(rnd_fwd());
    prog.push_back(mk(OP_BEGIN, 2'($urandom), 16'($urandom_range(3))));
    n = $urandom_range(1, 2);
    for (int i = 0; i < n; i++) prog.push_back(rnd_fwd());
    if ($urandom_range(1) == 1) begin
      prog.push_back(mk(OP_BEGIN, 2'($urandom), 16'($urandom_range(3))));
      n = $urandom_range(1, 2);
      for (int i = 0; i < n; i++) prog.push_back(rnd_fwd());
      prog.push_back(mk(OP_END, 2'($urandom), 16'($urandom)));
    end
    if ($urandom_range(1) == 1) prog.push_back(rnd_fwd());
    prog.push_back(mk(OP_END, 2'($urandom), 16'($urandom)));
    n = $urandom_range(2);
    for (int i = 0; i < n; i++) prog.push_back(rnd_fwd());
    if ($urandom_range(4) == 0) prog.push_back(mk(OP_END, 2'b00, 16'd0));
    if ($urandom_range(5) == 0) begin
      for (int i = 0; i < 3; i++) prog.push_back(mk(OP_BEGIN, 2'b00, 16'd1));
    end
    prog.push_back(mk(OP_HALT, 2'($urandom), 16'($urandom)));
  endtask

  int tc, fc, cy, fc0, cy0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    sif.progWrite = 1'b0;
    sif.progAddr  = '0;
    sif.progData  = '0;
    sif.start     = 1'b0;
    sif.hold      = 1'b0;
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = NOP_W;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_instr", 32'(sif.instruction), 32'(NOP_W));
    chk("rst_busy", 32'(sif.busy), 32'd0);
    chk("rst_done", 32'(sif.done), 32'd0);
    chk("rst_err", 32'(sif.error), 32'd0);
    chk("rst_pc", 32'(sif.pc), 32'd0);
    RST = 1'b0;

    prog = '{mk(OP_CONV, 2'd2, 16'd0), mk(OP_LOADK, 2'd0, 16'd0), mk(OP_HALT, 2'd0, 16'd0)};
    load_prog();
    run_prog("linear", 0, 0, 0, OP_CONV, tc, fc, cy);
    chk("linear_conv_cnt", 32'(tc), 32'd1);
    chk("linear_fwd_cnt", 32'(fc), 32'd2);

    prog = '{mk(OP_BEGIN, 2'd0, 16'd3), mk(OP_POOL, 2'd1, 16'd0), mk(OP_END, 2'd0, 16'd0), mk(OP_HALT, 2'd0, 16'd0)};
    load_prog();
    run_prog("loop", 0, 0, 0, OP_POOL, tc, fc0, cy0);
    chk("loop_pool_cnt", 32'(tc), 32'd3);
    run_prog("loop_hold", 0, 3, 5, OP_POOL, tc, fc, cy);
    chk("hold_pool_cnt", 32'(tc), 32'd3);
    chk("hold_fwd_same", 32'(fc), 32'(fc0));
    chk("hold_extra_cycles", 32'(cy), 32'(cy0 + 5));

    prog = '{mk(OP_BEGIN, 2'd0, 16'd2), mk(OP_BEGIN, 2'd0, 16'd2), mk(OP_CONV, 2'd0, 16'd0),
             mk(OP_END, 2'd0, 16'd0), mk(OP_END, 2'd0, 16'd0), mk(OP_HALT, 2'd0, 16'd0)};
    load_prog();
    run_prog("nest22", 10, 0, 0, OP_CONV, tc, fc, cy);
    chk("nest22_conv_cnt", 32'(tc), 32'd4);
    prog[0] = mk(OP_BEGIN, 2'd0, 16'd0);
    load_prog();
    run_prog("nest02", 10, 0, 0, OP_CONV, tc, fc, cy);
    chk("nest02_conv_cnt", 32'(tc), 32'd2);

    prog = '{mk(OP_BEGIN, 2'd0, 16'd1), mk(OP_BEGIN, 2'd0, 16'd1), mk(OP_BEGIN, 2'd0, 16'd1), mk(OP_HALT, 2'd0, 16'd0)};
    load_prog();
    run_prog("overflow", 0, 0, 0, OP_CONV, tc, fc, cy);
    chk("overflow_err", 32'(sif.error), 32'd1);
    chk("overflow_cycles", 32'(cy), 32'd3);

    prog = '{mk(OP_END, 2'd0, 16'd0), mk(OP_HALT, 2'd0, 16'd0)};
    load_prog();
    run_prog("underflow", 0, 0, 0, OP_CONV, tc, fc, cy);
    chk("underflow_err", 32'(sif.error), 32'd1);

    prog.delete();
    for (int i = 0; i < MEM_N; i++) prog.push_back(rnd_fwd());
    load_prog();
    run_prog("pc_wrap", 5, 0, 0, OP_CONV, tc, fc, cy);
    chk("pc_wrap_fwd", 32'(fc), 32'(MEM_N));

    for (int r = 0; r < 15; r++) begin
      gen_random();
      load_prog();
      run_prog($sformatf("rand%0d", r), 20, 0, 0, OP_POOL, tc, fc, cy);
    end

    prog = '{mk(OP_BEGIN, 2'd0, 16'd50), mk(OP_POOL, 2'd0, 16'd0), mk(OP_END, 2'd0, 16'd0), mk(OP_HALT, 2'd0, 16'd0)};
    load_prog();
    sif.start = 1'b1;
    @(posedge CLK); #1;
    sif.start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    sif.progWrite = 1'b1;
    sif.progAddr  = 8'd1;
    sif.progData  = mk(OP_CONV, 2'd3, 16'hBEEF);
    @(posedge CLK); #1;
    sif.progWrite = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("midrun_busy", 32'(sif.busy), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_busy", 32'(sif.busy), 32'd0);
    chk("abort_instr", 32'(sif.instruction), 32'(NOP_W));
    chk("abort_pc", 32'(sif.pc), 32'd0);
    chk("abort_done", 32'(sif.done), 32'd0);
    @(posedge CLK); #1;
    chk("abort_done_next", 32'(sif.done), 32'd0);
    run_prog("rerun", 0, 0, 0, OP_POOL, tc, fc, cy);
    chk("rerun_pool_cnt", 32'(tc), 32'd50);
    chk("rerun_no_conv", 32'(fc), 32'd50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
